// File: rtl/enc_cnt_packer_pkg.sv
// rtl/enc_cnt_packer_pkg.sv - shared types and constants for the encoder counter packer
//
// Purpose: packet magic, counter width, serializer state encoding, FIFO entry
//          layout and the packet header builder.
package enc_cnt_packer_pkg;

  localparam logic [7:0] ENC_PKT_MAGIC = 8'hA5;
  localparam int         ENC_CNT_W     = 64;
  localparam int         ENC_SEQ_W     = 16;

  // One-hot serializer states.
  typedef enum logic [3:0] {
    SER_IDLE = 4'b0001,
    SER_W0   = 4'b0010,
    SER_W1   = 4'b0100,
    SER_W2   = 4'b1000
  } ser_state_t;

  // FIFO entry: {overflow, seq, cnt}.
  typedef struct packed {
    logic                 ovf;
    logic [ENC_SEQ_W-1:0] seq;
    logic [ENC_CNT_W-1:0] cnt;
  } sample_t;

  localparam int SAMPLE_W = $bits(sample_t);

  // First packet word: {magic, seq, 7'b0, ovf}.
  function automatic logic [31:0] pkt_header(input sample_t s);
    return {ENC_PKT_MAGIC, s.seq, 7'b0, s.ovf};
  endfunction

endpackage

// File: rtl/enc_sample_fifo.sv
// rtl/enc_sample_fifo.sv - synchronous sample FIFO with occupancy level
//
// Purpose: buffers captured samples between capture logic and the serializer.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, din      write request and data (ignored when full)
//   pop, dout      read request (ignored when empty); dout shows the head entry
//   full, empty    occupancy flags
//   level          number of stored entries
module enc_sample_fifo #(
  parameter int P_DEPTH = 16,
  parameter int P_WIDTH = 81
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [P_WIDTH-1:0]         din,
  input  logic                       pop,
  output logic [P_WIDTH-1:0]         dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(P_DEPTH):0]   level
);

  localparam int AW = $clog2(P_DEPTH);

  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               do_push;
  logic               do_pop;

  // Extra pointer MSB tells a full buffer apart from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/enc_cnt_packer.sv
// rtl/enc_cnt_packer.sv - captures encoder counter samples and emits 3-word stream packets
//
// Purpose: on each armed ready strobe, queue {ovf, seq, cnt}; serialize each
//          entry as W0={A5,seq,7'b0,ovf}, W1=cnt[63:32], W2=cnt[31:0] (tlast).
// Ports:
//   CLK, I_RST_N          clock, asynchronous active-low reset
//   I_ARM                 acquisition enable; low clears seq and drop count
//   I_CNT, I_OVERFLOW     sample captured when I_READY is high
//   I_READY               one-cycle sample strobe
//   O_TDATA/O_TVALID/O_TLAST, I_TREADY   packet stream
//   O_LEVEL, O_FULL       FIFO occupancy (packet in serializer not counted)
//   O_DROP_CNT            saturating count of samples lost to a full FIFO
module enc_cnt_packer
  import enc_cnt_packer_pkg::*;
#(
  parameter int P_DEPTH = 16,
  parameter int P_SEQ_W = 16
) (
  input  logic                      CLK,
  input  logic                      I_RST_N,
  input  logic                      I_ARM,
  input  logic [63:0]               I_CNT,
  input  logic                      I_OVERFLOW,
  input  logic                      I_READY,
  output logic [31:0]               O_TDATA,
  output logic                      O_TVALID,
  input  logic                      I_TREADY,
  output logic                      O_TLAST,
  output logic [$clog2(P_DEPTH):0]  O_LEVEL,
  output logic                      O_FULL,
  output logic [15:0]               O_DROP_CNT
);

  logic [P_SEQ_W-1:0]  seq_q;
  logic [15:0]         drop_q;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [SAMPLE_W-1:0] fifo_din;
  logic [SAMPLE_W-1:0] fifo_dout;
  sample_t             sample_in;
  sample_t             head;

  ser_state_t          state_q, state_d;
  logic [31:0]         tdata_q, tdata_d;
  logic                tlast_q, tlast_d;
  logic                tvalid_q, tvalid_d;
  logic [63:0]         cnt_q;
  logic                hs;

  // ---------------- capture ----------------
  assign sample_in = '{ovf: I_OVERFLOW, seq: seq_q, cnt: I_CNT};
  assign fifo_din  = sample_in;
  // Full is the pre-edge state; a pop on the same edge does not make room.
  assign fifo_push = I_ARM && I_READY && !fifo_full;

  always_ff @(posedge CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      seq_q  <= '0;
      drop_q <= '0;
    end else if (!I_ARM) begin
      seq_q  <= '0;
      drop_q <= '0;
    end else if (I_READY) begin
      // seq advances on drops too so the host sees the gap.
      seq_q <= seq_q + 1'b1;
      if (fifo_full && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
    end
  end

  enc_sample_fifo #(
    .P_DEPTH (P_DEPTH),
    .P_WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (I_RST_N),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (O_LEVEL)
  );

  assign head = fifo_dout;

  // ---------------- serializer ----------------
  assign hs = tvalid_q && I_TREADY;

  always_ff @(posedge CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q  <= SER_IDLE;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      // W0 is built straight from the FIFO head; only the count is kept for W1/W2.
      if (fifo_pop) cnt_q <= head.cnt;
    end
  end

  always_comb begin
    state_d  = state_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      SER_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = SER_W0;
          tdata_d  = pkt_header(head);
          tlast_d  = 1'b0;
          tvalid_d = 1'b1;
        end
      end
      SER_W0: begin
        if (hs) begin
          state_d = SER_W1;
          tdata_d = cnt_q[63:32];
        end
      end
      SER_W1: begin
        if (hs) begin
          state_d = SER_W2;
          tdata_d = cnt_q[31:0];
          tlast_d = 1'b1;
        end
      end
      SER_W2: begin
        if (hs) begin
          if (!fifo_empty) begin
            // Load the next packet on the last handshake: no idle cycle between packets.
            fifo_pop = 1'b1;
            state_d  = SER_W0;
            tdata_d  = pkt_header(head);
            tlast_d  = 1'b0;
          end else begin
            state_d  = SER_IDLE;
            tdata_d  = '0;
            tlast_d  = 1'b0;
            tvalid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d  = SER_IDLE;
        tdata_d  = '0;
        tlast_d  = 1'b0;
        tvalid_d = 1'b0;
      end
    endcase
  end

  assign O_TDATA    = tdata_q;
  assign O_TLAST    = tlast_q;
  assign O_TVALID   = tvalid_q;
  assign O_FULL     = fifo_full;
  assign O_DROP_CNT = drop_q;

endmodule
